// File: rtl/sdram_responder.sv
// Behavioural SDRAM chip stand-in: decodes single-word commands, tracks per-bank
// open rows and tRCD, serves reads/writes from a word array, flags protocol violations.
module sdram_responder #(
  parameter int MEM_AW = 12,
  parameter int TRCD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sd_ncs,
  input  logic        sd_nras,
  input  logic        sd_ncas,
  input  logic        sd_nwe,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_a,
  input  logic        sd_dqml,
  input  logic        sd_dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        mode_valid,
  output logic [1:0]  cas_lat,
  output logic [15:0] refresh_cnt,
  output logic [6:0]  err
);

  localparam int CW = (TRCD < 1) ? 1 : $clog2(TRCD + 1);
  localparam logic [CW-1:0] TRCD_C = CW'(TRCD);

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
  } rd_slot_t;

  cmd_e                cmd;
  logic [3:0]          open_q, open_d;
  logic [3:0][12:0]    row_q, row_d;
  logic [3:0][CW-1:0]  cnt_q, cnt_d, cnt_now;
  logic                mode_valid_q, mode_valid_d;
  logic [1:0]          cas_lat_q, cas_lat_d;
  logic [15:0]         ref_q, ref_d;
  logic [6:0]          err_q, err_d;
  rd_slot_t [2:0]      pipe_q, pipe_d;
  logic [15:0]         dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         mem_q [2**MEM_AW];
  logic [MEM_AW-1:0]   idx;
  logic [1:0]          mem_we;
  logic                acc_bad;
  logic                lmr_ok;

  assign cmd = sd_ncs ? CMD_NOP : cmd_e'({sd_nras, sd_ncas, sd_nwe});
  assign idx = MEM_AW'({sd_ba, row_q[sd_ba], sd_a[8:0]});

  always_comb begin
    open_d       = open_q;
    row_d        = row_q;
    mode_valid_d = mode_valid_q;
    cas_lat_d    = cas_lat_q;
    ref_d        = ref_q;
    err_d        = err_q;
    mem_we       = '0;
    // cnt_now counts this edge too, so ACTIVE at N makes edge N+TRCD the first legal access
    for (int unsigned b = 0; b < 4; b++) begin
      cnt_now[b] = (cnt_q[b] >= TRCD_C) ? cnt_q[b] : cnt_q[b] + 1'b1;
    end
    cnt_d = cnt_now;
    // slot k reaches the output k+1 edges after it is loaded
    pipe_d[0] = pipe_q[1];
    pipe_d[1] = pipe_q[2];
    pipe_d[2] = '0;
    dq_oe_d   = pipe_q[0].v;
    dq_out_d  = pipe_q[0].v ? pipe_q[0].d : '0;
    acc_bad   = !mode_valid_q || !open_q[sd_ba] || (cnt_now[sd_ba] < TRCD_C);
    lmr_ok    = !(|open_q) && (sd_a[2:0] == 3'b000) &&
                ((sd_a[6:4] == 3'b010) || (sd_a[6:4] == 3'b011));

    case (cmd)
      CMD_ACT: begin
        if (open_q[sd_ba]) begin
          err_d[0] = 1'b1;
        end else begin
          open_d[sd_ba] = 1'b1;
          row_d[sd_ba]  = sd_a;
          cnt_d[sd_ba]  = '0;
        end
      end
      CMD_PRE: begin
        if (sd_a[10]) open_d = '0;
        else          open_d[sd_ba] = 1'b0;
      end
      CMD_REF: begin
        if (|open_q)           err_d[3] = 1'b1;
        else if (ref_q != '1)  ref_d = ref_q + 16'd1;
      end
      CMD_LMR: begin
        if (!lmr_ok) begin
          err_d[5] = 1'b1;
        end else begin
          mode_valid_d = 1'b1;
          cas_lat_d    = sd_a[5:4];
        end
      end
      CMD_RD, CMD_WR: begin
        if (!mode_valid_q)                 err_d[4] = 1'b1;
        if (!open_q[sd_ba])                err_d[1] = 1'b1;
        if (cnt_now[sd_ba] < TRCD_C)       err_d[2] = 1'b1;
        if (cmd == CMD_WR) begin
          // conflict window covers the cycle read data is launched and the cycle it is held
          if (dq_oe_q || pipe_q[0].v) err_d[6] = 1'b1;
          if (!acc_bad) mem_we = {~sd_dqmh, ~sd_dqml};
        end else if (!acc_bad) begin
          if (cas_lat_q == 2'd3) pipe_d[2] = '{v: 1'b1, d: mem_q[idx]};
          else                   pipe_d[1] = '{v: 1'b1, d: mem_q[idx]};
        end
        if (sd_a[10]) open_d[sd_ba] = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_q       <= '0;
      row_q        <= '0;
      cnt_q        <= {4{TRCD_C}};
      mode_valid_q <= 1'b0;
      cas_lat_q    <= 2'd2;
      ref_q        <= '0;
      err_q        <= '0;
      pipe_q       <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
    end else begin
      open_q       <= open_d;
      row_q        <= row_d;
      cnt_q        <= cnt_d;
      mode_valid_q <= mode_valid_d;
      cas_lat_q    <= cas_lat_d;
      ref_q        <= ref_d;
      err_q        <= err_d;
      pipe_q       <= pipe_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_we[0]) mem_q[idx][7:0]  <= dq_in[7:0];
    if (!reset && mem_we[1]) mem_q[idx][15:8] <= dq_in[15:8];
  end

  assign dq_out      = dq_out_q;
  assign dq_oe       = dq_oe_q;
  assign mode_valid  = mode_valid_q;
  assign cas_lat     = cas_lat_q;
  assign refresh_cnt = ref_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Self-checking bench for sdram_responder: directed scenarios plus a randomized
// command stream checked against a transaction-level model of the SDRAM rules.
module tb_sdram_responder;

  localparam int TRCD = 2;

  typedef enum logic [2:0] {
    C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
    C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd_ncs, sd_nras, sd_ncas, sd_nwe;
  logic [1:0]  sd_ba;
  logic [12:0] sd_a;
  logic        sd_dqml, sd_dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        mode_valid;
  logic [1:0]  cas_lat;
  logic [15:0] refresh_cnt;
  logic [6:0]  err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // reference model state
  bit          m_open [4];
  logic [12:0] m_row  [4];
  int          m_act  [4];
  bit          m_mv;
  logic [1:0]  m_cl;
  logic [15:0] m_ref;
  logic [6:0]  m_err;
  logic [15:0] m_mem   [4096];
  logic [1:0]  m_known [4096];
  logic [15:0] due_d [int];
  bit          due_k [int];

  always #5 clk = ~clk;

  sdram_responder #(.MEM_AW(12), .TRCD(TRCD)) dut (
    .clk(clk), .reset(reset),
    .sd_ncs(sd_ncs), .sd_nras(sd_nras), .sd_ncas(sd_ncas), .sd_nwe(sd_nwe),
    .sd_ba(sd_ba), .sd_a(sd_a), .sd_dqml(sd_dqml), .sd_dqmh(sd_dqmh),
    .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
    .mode_valid(mode_valid), .cas_lat(cas_lat), .refresh_cnt(refresh_cnt), .err(err)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = '0;
      m_act[i]  = -1000;
    end
    m_mv  = 1'b0;
    m_cl  = 2'd2;
    m_ref = '0;
    m_err = '0;
    due_d.delete();
    due_k.delete();
  endtask

  // Drive one command, let the edge sample it, then advance the model to that edge.
  task automatic tick(input bit rst, input bit sel, input cmd_t c, input logic [1:0] ba,
                      input logic [12:0] a, input bit ml, input bit mh, input logic [15:0] din);
    int  e;
    int  addr;
    bit  bad;
    bit  any_open;
    reset   = rst;
    sd_ncs  = !sel;
    {sd_nras, sd_ncas, sd_nwe} = sel ? c : 3'($urandom_range(0, 7));
    sd_ba   = ba;
    sd_a    = a;
    sd_dqml = ml;
    sd_dqmh = mh;
    dq_in   = din;
    @(posedge clk);
    #1;
    edge_n++;
    e = edge_n;
    any_open = m_open[0] | m_open[1] | m_open[2] | m_open[3];
    if (rst) begin
      model_reset();
    end else if (sel) begin
      case (c)
        C_ACT: begin
          if (m_open[ba]) m_err[0] = 1'b1;
          else begin m_open[ba] = 1'b1; m_row[ba] = a; m_act[ba] = e; end
        end
        C_PRE: begin
          if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
          else m_open[ba] = 1'b0;
        end
        C_REF: begin
          if (any_open) m_err[3] = 1'b1;
          else if (m_ref != 16'hFFFF) m_ref = m_ref + 16'd1;
        end
        C_LMR: begin
          if (any_open || a[2:0] != 3'd0 || !(a[6:4] == 3'd2 || a[6:4] == 3'd3)) m_err[5] = 1'b1;
          else begin m_mv = 1'b1; m_cl = a[5:4]; end
        end
        C_RD, C_WR: begin
          bad = 1'b0;
          if (!m_mv)               begin m_err[4] = 1'b1; bad = 1'b1; end
          if (!m_open[ba])         begin m_err[1] = 1'b1; bad = 1'b1; end
          if (e - m_act[ba] < TRCD) begin m_err[2] = 1'b1; bad = 1'b1; end
          addr = (int'(ba) * (1 << 22) + int'(m_row[ba]) * 512 + int'(a[8:0])) % 4096;
          if (c == C_WR) begin
            if (due_d.exists(e) || due_d.exists(e - 1)) m_err[6] = 1'b1;
            if (!bad && !ml) begin m_mem[addr][7:0]  = din[7:0];  m_known[addr][0] = 1'b1; end
            if (!bad && !mh) begin m_mem[addr][15:8] = din[15:8]; m_known[addr][1] = 1'b1; end
          end else if (!bad) begin
            due_d[e + int'(m_cl)] = m_mem[addr];
            due_k[e + int'(m_cl)] = (m_known[addr] == 2'b11);
          end
          if (a[10]) m_open[ba] = 1'b0;
        end
        default: ;
      endcase
    end
  endtask

  task automatic nop();
    tick(1'b0, 1'b0, C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic cmd(input cmd_t c, input logic [1:0] ba, input logic [12:0] a,
                     input logic [15:0] din, input bit mh);
    tick(1'b0, 1'b1, c, ba, a, 1'b0, mh, din);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    tick(1'b1, 1'b0, C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dq_oe !== 1'b0 || dq_out !== 16'h0 || mode_valid !== 1'b0 || cas_lat !== 2'd2 ||
        refresh_cnt !== 16'h0 || err !== 7'h0) begin
      errors++;
      $display("FAIL reset_state: oe=%b out=%h mv=%b cl=%0d ref=%0d err=%h, required 0/0000/0/2/0/00",
               dq_oe, dq_out, mode_valid, cas_lat, refresh_cnt, err);
    end
  endtask

  task automatic test_init();
    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0);
    cmd(C_REF, 2'd0, 13'h0, 16'h0, 1'b0);
    cmd(C_REF, 2'd0, 13'h0, 16'h0, 1'b0);
    cmd(C_LMR, 2'd0, 13'h220, 16'h0, 1'b0);
    checks++;
    if (mode_valid !== 1'b1 || cas_lat !== 2'd2 || refresh_cnt !== 16'd2 || err !== 7'h0) begin
      errors++;
      $display("FAIL init: mv=%b cl=%0d ref=%0d err=%h, required 1/2/2/00", mode_valid, cas_lat, refresh_cnt, err);
    end
  endtask

  task automatic test_write_read();
    cmd(C_ACT, 2'd1, 13'h155, 16'h0, 1'b0);
    nop();
    cmd(C_WR, 2'd1, 13'h0A4, 16'hBEEF, 1'b0);
    checks++;
    if (err !== 7'h0) begin
      errors++; $display("FAIL trcd_boundary: err=%h required 00", err);
    end
    cmd(C_RD, 2'd1, 13'h0A4, 16'h0, 1'b0);
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) nop();
      checks++;
      if (k == 2 ? (dq_oe !== 1'b1 || dq_out !== 16'hBEEF) : (dq_oe !== 1'b0)) begin
        errors++;
        $display("FAIL rd_cl2 N+%0d: oe=%b out=%h, required oe=%0d out=beef", k, dq_oe, dq_out, k == 2);
      end
    end
  endtask

  task automatic test_mask_and_cl3();
    tick(1'b0, 1'b1, C_WR, 2'd1, 13'h0A4, 1'b0, 1'b1, 16'h1234);
    cmd(C_RD, 2'd1, 13'h0A4, 16'h0, 1'b0);
    nop();
    nop();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'hBE34) begin
      errors++; $display("FAIL byte_mask: oe=%b out=%h, required 1/be34", dq_oe, dq_out);
    end
    nop();
    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0);
    cmd(C_LMR, 2'd0, 13'h230, 16'h0, 1'b0);
    checks++;
    if (cas_lat !== 2'd3 || err !== 7'h0) begin
      errors++; $display("FAIL lmr_cl3: cl=%0d err=%h, required 3/00", cas_lat, err);
    end
    cmd(C_ACT, 2'd1, 13'h155, 16'h0, 1'b0);
    nop();
    cmd(C_RD, 2'd1, 13'h0A4, 16'h0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      nop();
      checks++;
      if (k == 3 ? (dq_oe !== 1'b1 || dq_out !== 16'hBE34) : (dq_oe !== 1'b0)) begin
        errors++;
        $display("FAIL rd_cl3 N+%0d: oe=%b out=%h, required oe=%0d out=be34", k, dq_oe, dq_out, k == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) cmd(C_WR, 2'd1, 13'(i), 16'h1000 + 16'(i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) cmd(C_RD, 2'd1, 13'(i), 16'h0, 1'b0);
      else nop();
      checks++;
      if ((i >= 3 && i <= 6) ? (dq_oe !== 1'b1 || dq_out !== 16'h1000 + 16'(i - 3)) : (dq_oe !== 1'b0)) begin
        errors++;
        $display("FAIL back_to_back R+%0d: oe=%b out=%h, required oe=%0d out=%h",
                 i, dq_oe, dq_out, (i >= 3 && i <= 6), 16'h1000 + 16'(i - 3));
      end
    end
  endtask

  task automatic test_autoprecharge();
    cmd(C_RD, 2'd1, 13'h400, 16'h0, 1'b0);
    cmd(C_ACT, 2'd1, 13'h155, 16'h0, 1'b0);
    nop();
    nop();
    checks++;
    if (err !== 7'h0 || dq_oe !== 1'b1 || dq_out !== 16'h1000) begin
      errors++; $display("FAIL auto_precharge: err=%h oe=%b out=%h, required 00/1/1000", err, dq_oe, dq_out);
    end
    nop();
  endtask

  task automatic test_violations();
    do_reset();
    cmd(C_ACT, 2'd0, 13'd5, 16'h0, 1'b0);
    nop();
    nop();
    cmd(C_RD, 2'd0, 13'd0, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h10) begin errors++; $display("FAIL no_mode: err=%h required 10", err); end
    cmd(C_PRE, 2'd0, 13'h400, 16'h0, 1'b0);
    cmd(C_LMR, 2'd0, 13'h220, 16'h0, 1'b0);
    cmd(C_ACT, 2'd0, 13'd5, 16'h0, 1'b0);
    cmd(C_ACT, 2'd0, 13'd6, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h11) begin errors++; $display("FAIL double_act: err=%h required 11", err); end
    cmd(C_RD, 2'd2, 13'd1, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h13) begin errors++; $display("FAIL closed_bank: err=%h required 13", err); end
    cmd(C_ACT, 2'd3, 13'd7, 16'h0, 1'b0);
    cmd(C_RD, 2'd3, 13'd1, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h17) begin errors++; $display("FAIL trcd_early: err=%h required 17", err); end
    for (int k = 0; k < 4; k++) begin
      nop();
      checks++;
      if (dq_oe !== 1'b0) begin errors++; $display("FAIL suppressed_read %0d: oe=%b required 0", k, dq_oe); end
    end
    cmd(C_REF, 2'd0, 13'd0, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h1F || refresh_cnt !== 16'd0) begin
      errors++; $display("FAIL ref_open: err=%h ref=%0d, required 1f/0", err, refresh_cnt);
    end
    cmd(C_LMR, 2'd0, 13'h230, 16'h0, 1'b0);
    checks++;
    if (err !== 7'h3F || cas_lat !== 2'd2) begin
      errors++; $display("FAIL lmr_open: err=%h cl=%0d, required 3f/2", err, cas_lat);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    cmd(C_LMR, 2'd0, 13'h220, 16'h0, 1'b0);
    cmd(C_ACT, 2'd1, 13'h155, 16'h0, 1'b0);
    nop();
    cmd(C_WR, 2'd1, 13'h010, 16'hA5A5, 1'b0);
    cmd(C_RD, 2'd1, 13'h010, 16'h0, 1'b0);
    nop();
    cmd(C_WR, 2'd1, 13'h011, 16'h5A5A, 1'b0);
    checks++;
    if (err !== 7'h40 || dq_oe !== 1'b1 || dq_out !== 16'hA5A5) begin
      errors++; $display("FAIL bus_conflict: err=%h oe=%b out=%h, required 40/1/a5a5", err, dq_oe, dq_out);
    end
    nop();
    nop();
    cmd(C_RD, 2'd1, 13'h011, 16'h0, 1'b0);
    nop();
    nop();
    checks++;
    if (dq_oe !== 1'b1 || dq_out !== 16'h5A5A) begin
      errors++; $display("FAIL conflict_write_kept: oe=%b out=%h, required 1/5a5a", dq_oe, dq_out);
    end
  endtask

  task automatic test_reset_inflight();
    cmd(C_RD, 2'd1, 13'h010, 16'h0, 1'b0);
    cmd(C_RD, 2'd1, 13'h011, 16'h0, 1'b0);
    tick(1'b1, 1'b0, C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    checks++;
    if (dq_oe !== 1'b0 || err !== 7'h0 || mode_valid !== 1'b0) begin
      errors++; $display("FAIL reset_inflight: oe=%b err=%h mv=%b, required 0/00/0", dq_oe, err, mode_valid);
    end
    tick(1'b1, 1'b0, C_NOP, 2'd0, 13'd0, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      nop();
      checks++;
      if (dq_oe !== 1'b0) begin errors++; $display("FAIL reset_drain %0d: oe=%b required 0", k, dq_oe); end
    end
  endtask

  task automatic test_random();
    cmd_t        c;
    logic [12:0] a;
    int          r;
    bit          exp_oe;
    do_reset();
    cmd(C_LMR, 2'd0, ($urandom_range(0, 1) == 0) ? 13'h220 : 13'h230, 16'h0, 1'b0);
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 15);
      c = (r < 3) ? C_ACT : (r < 5) ? C_PRE : (r < 9) ? C_RD : (r < 12) ? C_WR :
          (r == 12) ? C_REF : (r == 13) ? C_LMR : (r == 14) ? C_BST : C_NOP;
      case (c)
        C_ACT:       a = 13'($urandom_range(0, 3));
        C_RD, C_WR:  a = 13'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 13'h400 : 13'h0);
        C_LMR: begin
          r = $urandom_range(0, 3);
          a = (r == 0) ? 13'h220 : (r == 1) ? 13'h230 : (r == 2) ? 13'h240 : 13'h221;
        end
        default:     a = 13'($urandom_range(0, 8191));
      endcase
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, c, 2'($urandom_range(0, 3)), a,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      exp_oe = due_d.exists(edge_n);
      checks++;
      if (dq_oe !== exp_oe || err !== m_err || refresh_cnt !== m_ref ||
          mode_valid !== m_mv || cas_lat !== m_cl) begin
        errors++;
        $display("FAIL random_state edge %0d: oe=%b err=%h ref=%0d mv=%b cl=%0d, required %b/%h/%0d/%b/%0d",
                 edge_n, dq_oe, err, refresh_cnt, mode_valid, cas_lat, exp_oe, m_err, m_ref, m_mv, m_cl);
      end
      if (exp_oe && due_k[edge_n]) begin
        checks++;
        if (dq_out !== due_d[edge_n]) begin
          errors++;
          $display("FAIL random_data edge %0d: out=%h required %h", edge_n, dq_out, due_d[edge_n]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 2'b00;
    model_reset();
    test_reset();
    test_init();
    test_write_read();
    test_mask_and_cl3();
    test_back_to_back();
    test_autoprecharge();
    test_violations();
    test_conflict();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
